// File: rtl/pulse_width_meter.sv
// pulse_width_meter: per-channel high-time measurement in prescaled ticks with saturation and glitch rejection.
// Optional PULSE_WIDTH_METER_AVG_EN: report the mean of the last four accepted widths.
module pulse_width_meter #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 13,
    parameter int PRESCALE    = 100,
    parameter int RESET_WIDTH = 300,
    parameter int MIN_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         vin,
    output logic [N_CH*CNT_W-1:0]   out,
    output logic [N_CH-1:0]         valid,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         glitch
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] MAX_CNT = '1;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_WIDTH);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

    logic [N_CH-1:0] s1_q, s2_q;
    logic [PW-1:0]   pre_q, pre_d;
    logic            tick;

    assign tick  = pre_q == PW'(PRESCALE - 1);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            pre_q <= '0;
        end else begin
            s1_q  <= vin;
            s2_q  <= s1_q;
            pre_q <= pre_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, out_q;
        logic             acc, rej, valid_q, ovf_q, glitch_q;
        logic             vs;

        assign vs = s2_q[g];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            acc     = 1'b0;
            rej     = 1'b0;
            if (tick) begin
                case (state_q)
                    WAIT_LOW: state_d = vs ? WAIT_LOW : IDLE;
                    IDLE: if (vs) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                    HIGH: if (vs) begin
                        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        acc     = cnt_q >= MIN_CNT;
                        rej     = cnt_q < MIN_CNT;
                    end
                    default: state_d = WAIT_LOW;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= WAIT_LOW;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                ovf_q    <= acc ? (cnt_q == MAX_CNT) : ovf_q;
                glitch_q <= rej;
            end
        end

`ifdef PULSE_WIDTH_METER_AVG_EN
        logic [CNT_W-1:0] hist_q [4];
        logic [1:0]       ptr_q;
        logic             acc_q;
        logic [CNT_W+1:0] sum;

        // history is written on the accept edge, so the mean is registered one clk later
        assign sum = {2'b0, hist_q[0]} + {2'b0, hist_q[1]} + {2'b0, hist_q[2]} + {2'b0, hist_q[3]};

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hist_q  <= '{default: RST_VAL};
                ptr_q   <= '0;
                acc_q   <= 1'b0;
                valid_q <= 1'b0;
                out_q   <= RST_VAL;
            end else begin
                if (acc) begin
                    hist_q[ptr_q] <= cnt_q;
                    ptr_q         <= ptr_q + 1'b1;
                end
                acc_q   <= acc;
                valid_q <= acc_q;
                out_q   <= acc_q ? CNT_W'(sum >> 2) : out_q;
            end
        end
`else
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                out_q   <= RST_VAL;
            end else begin
                valid_q <= acc;
                out_q   <= acc ? cnt_q : out_q;
            end
        end
`endif

        assign out[g*CNT_W +: CNT_W] = out_q;
        assign valid[g]              = valid_q;
        assign ovf[g]                = ovf_q;
        assign glitch[g]             = glitch_q;
    end
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed table-driven checks of pulse_width_meter with N_CH=2, CNT_W=8, PRESCALE=4.
// Pulses are driven for whole multiples of PRESCALE clocks, so the tick count is phase-independent.
module tb_pulse_width_meter;
    localparam int N = 2, W = 8, P = 4, RW = 100, MW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   vin = '0;
    logic [N*W-1:0] out;
    logic [N-1:0]   valid, ovf, glitch;

    pulse_width_meter #(.N_CH(N), .CNT_W(W), .PRESCALE(P), .RESET_WIDTH(RW), .MIN_WIDTH(MW)) dut (
        .clk(clk), .reset(reset), .vin(vin), .out(out), .valid(valid), .ovf(ovf), .glitch(glitch)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int vcnt [2] = '{0, 0};
    int gcnt [2] = '{0, 0};
    int both_err = 0;
    int lat;

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                if (valid[k]) vcnt[k]++;
                if (glitch[k]) gcnt[k]++;
                if (valid[k] && glitch[k]) both_err++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // drive both channels high for l0/l1 clocks, then low; lat = clks from fall to first valid (-1 if none)
    task automatic run_pulse(input int l0, input int l1);
        int len;
        len = (l0 > l1) ? l0 : l1;
        for (int c = 0; c <= len; c++) begin
            @(posedge clk);
            #1;
            vin[0] = c < l0;
            vin[1] = c < l1;
        end
        lat = -1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && valid != '0) lat = c;
        end
    endtask

    typedef struct {
        int l0, l1, e0, e1, ev0, ev1, eg0, eg1;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int v0, v1, g0, g1;
        tbl[0] = '{40, 0, 10, 100, 1, 0, 0, 0};
        tbl[1] = '{0, 4, 10, 100, 0, 0, 0, 1};
        tbl[2] = '{40, 24, 10, 6, 1, 1, 0, 0};
        tbl[3] = '{8, 12, 2, 3, 1, 1, 0, 0};
        tbl[4] = '{4, 4, 2, 3, 0, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out0", int'(out[7:0]), RW);
        check("rst_out1", int'(out[15:8]), RW);
        check("rst_valid", int'(valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_glitch", int'(glitch), 0);
        reset = 1'b1;
        repeat (10) @(posedge clk);

`ifndef PULSE_WIDTH_METER_AVG_EN
        for (int i = 0; i < 5; i++) begin
            v0 = vcnt[0]; v1 = vcnt[1]; g0 = gcnt[0]; g1 = gcnt[1];
            run_pulse(tbl[i].l0, tbl[i].l1);
            check($sformatf("row%0d_out0", i), int'(out[7:0]), tbl[i].e0);
            check($sformatf("row%0d_out1", i), int'(out[15:8]), tbl[i].e1);
            check($sformatf("row%0d_valid0", i), vcnt[0] - v0, tbl[i].ev0);
            check($sformatf("row%0d_valid1", i), vcnt[1] - v1, tbl[i].ev1);
            check($sformatf("row%0d_glitch0", i), gcnt[0] - g0, tbl[i].eg0);
            check($sformatf("row%0d_glitch1", i), gcnt[1] - g1, tbl[i].eg1);
            if (i == 0) check("lat_range", int'(lat >= 3 && lat <= P + 2), 1);
        end

        run_pulse(1200, 0);
        check("sat_out0", int'(out[7:0]), 255);
        check("sat_ovf0", int'(ovf[0]), 1);
        check("sat_ovf1", int'(ovf[1]), 0);
        run_pulse(20, 0);
        check("post_sat_out0", int'(out[7:0]), 5);
        check("post_sat_ovf0", int'(ovf[0]), 0);
        run_pulse(1200, 0);
        check("sat2_ovf0", int'(ovf[0]), 1);

        // async reset while ch0 is mid-pulse; it stays high through release
        vin[0] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_out0", int'(out[7:0]), RW);
        check("async_out1", int'(out[15:8]), RW);
        check("async_ovf", int'(ovf), 0);
        check("async_valid", int'(valid), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        v0 = vcnt[0];
        repeat (32) @(posedge clk);
        #1 vin[0] = 1'b0;
        repeat (12) @(posedge clk);
        check("wl_no_valid", vcnt[0] - v0, 0);
        run_pulse(28, 0);
        check("wl_valid_once", vcnt[0] - v0, 1);
        check("wl_out0", int'(out[7:0]), 7);
`else
        for (int i = 0; i < 4; i++) begin
            v0 = vcnt[0];
            run_pulse(40, 0);
            check($sformatf("avg%0d_out0", i), int'(out[7:0]), (i == 0) ? 77 : (i == 1) ? 55 : (i == 2) ? 32 : 10);
            check($sformatf("avg%0d_valid0", i), vcnt[0] - v0, 1);
            if (i == 0) check("avg_lat_range", int'(lat >= 4 && lat <= P + 3), 1);
        end
        check("avg_out1", int'(out[15:8]), RW);
`endif
        check("valid_glitch_excl", both_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Multi-channel, parametrised pulse-width measurement block for the theremin front end. It measures the high time of each digital input in units of a prescaled sample tick. Each channel has its own state machine, saturation and overflow reporting, glitch rejection and a per-result valid strobe. Results feed the pitch/volume mapping logic; a stable reset value keeps the synthesiser at a defined tone until the first real measurement.

## Interface
- `N_CH`, 4: number of independent input channels.
- `CNT_W`, 13: width of each width counter and result.
- `PRESCALE`, 100: clk cycles per sample tick; must be ≥ 2.
- `RESET_WIDTH`, 300: reset value of every result; must be < 2^CNT_W.
- `MIN_WIDTH`, 2: smallest accepted width in ticks; shorter pulses are rejected.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted when 0.
- `vin` in N_CH: raw pulse inputs, asynchronous to clk.
- `out` out N_CH*CNT_W: results. Channel k occupies bits [k*CNT_W +: CNT_W].
- `valid` out N_CH: 1-clk strobe per channel when that channel's `out` updates.
- `ovf` out N_CH: per channel, set if the last accepted pulse saturated. Held until the next accepted pulse.
- `glitch` out N_CH: 1-clk strobe per channel when a pulse is rejected as too short.

## Operation
- Each `vin` bit passes through a 2-flop synchronizer, giving `vin_s`. The synchronizers reset to 0.
- Shared prescaler:
  - Counts 0..PRESCALE-1 and wraps; resets to 0.
  - `tick` is true in the cycle where the count equals PRESCALE-1.
- Per-channel FSM, evaluated only on tick:
  - WAIT_LOW (reset state): stays while `vin_s`=1; goes to IDLE when `vin_s`=0. A pulse already high at reset release is never measured.
  - IDLE: on `vin_s`=1, goes to HIGH with cnt=1.
  - HIGH, `vin_s`=1: cnt = cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - HIGH, `vin_s`=0: goes to IDLE, then either accepts or rejects the pulse.
  - Accept (cnt ≥ MIN_WIDTH): out=cnt, valid=1 for one clk, ovf=(cnt==2^CNT_W-1).
  - Reject (cnt < MIN_WIDTH): glitch=1 for one clk; out and ovf unchanged.
- Channels are fully independent. Simultaneous events on several channels in one tick are all handled in that tick.
- valid and glitch are never both high for one channel in the same cycle.
- Asserting reset mid-pulse discards the measurement. After release, the channel starts in WAIT_LOW.

## Timing
- Reset values:
  - every out slice = RESET_WIDTH
  - valid, ovf, glitch = 0
  - FSMs in WAIT_LOW
  - prescaler = 0, synchronizers = 0
- Outputs take their reset values asynchronously when reset falls.
- Latency from a vin edge to its effect: 2 clk (synchronizer), plus wait for the next tick, plus 1 clk (registered outputs). Maximum is PRESCALE+2 clk.
- Measurement resolution is 1 tick. Result = number of ticks at which `vin_s` was sampled high. Pulse edges placed mid-tick-period give an exact count.
- valid and glitch are high for exactly one clk, in the cycle after the tick edge that closed the pulse.

## Configuration
- Macro: `PULSE_WIDTH_METER_AVG_EN`.
- Defined:
  - Each channel keeps a 4-entry history of accepted widths, all initialised to RESET_WIDTH on reset.
  - On each accept, the new width replaces the oldest entry.
  - out = floor(sum of 4 entries / 4), using a CNT_W+2 bit sum.
  - out and valid are delayed by one additional clk.
  - ovf still reflects the newest raw width.
  - Rejected pulses do not enter the history.
- Undefined: out is the raw accepted width. No history storage is synthesised.

## Test plan
Bench parameters: N_CH=2, CNT_W=8, PRESCALE=4, RESET_WIDTH=100, MIN_WIDTH=2.
- Reset held low, vin=0 → out={100,100}, valid=0, ovf=0, glitch=0. Drop reset mid-run → same values immediately, without waiting for a clk edge.
- After reset release with vin=0, ch0 high for exactly 40 clk, edges mid-tick → out[7:0]=10, valid[0] for 1 clk, ch1 unchanged. Repeat with both channels pulsed 10 and 6 ticks at once → both valid, correct values.
- ch1 high for 1 tick period → glitch[1] 1 clk, out[15:8]=100, valid[1]=0.
- ch0 held high 300 ticks then low → out[7:0]=255, ovf[0]=1. A following 5-tick pulse → out=5, ovf[0]=0.
- vin[0]=1 through reset release, low after 8 ticks, then a 7-tick pulse → only one valid, out=7.
- With PULSE_WIDTH_METER_AVG_EN: four 10-tick pulses after reset → successive outs 77, 55, 32, 10. Each valid arrives 1 clk later than in the non-AVG build.
